// File: rtl/mem_refill_arbiter.sv
// Main-memory line-read arbiter shared by the IC and DC refill engines.
// One refill is in flight at a time. When both caches miss together, a
// round-robin pointer picks the winner. A refill ends when memory answers
// or when the timeout expires, and every output comes straight from a flop.
//
// state | meaning
// IDLE  | no refill in flight; arbitrate pending requests
// BUSY  | refill owned by owner_dc_q; waiting for mem_read_valid_i or timeout
module mem_refill_arbiter #(
  parameter int LineSize       = 128,
  parameter int ByteOffsetBits = 4,
  parameter int TimeoutCycles  = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         ic_addr_i,
  input  logic                ic_read_en_i,
  output logic                ic_read_valid_o,
  output logic [LineSize-1:0] ic_read_data_o,
  output logic                ic_err_o,
  input  logic [31:0]         dc_addr_i,
  input  logic                dc_read_en_i,
  output logic                dc_read_valid_o,
  output logic [LineSize-1:0] dc_read_data_o,
  output logic                dc_err_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_read_en_o,
  input  logic                mem_read_valid_i,
  input  logic [LineSize-1:0] mem_read_data_i
);

  localparam int              CntW      = $clog2(TimeoutCycles) + 1;
  // The timer counts down from TimeoutCycles-1. Terminal count 0 falls on the
  // TimeoutCycles-th BUSY edge after the grant.
  localparam logic [CntW-1:0] CntLoad   = CntW'(TimeoutCycles - 1);
  localparam logic [31:0]     AlignMask = ~((32'd1 << ByteOffsetBits) - 32'd1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic                owner_dc_q, owner_dc_d;
  logic                fav_dc_q, fav_dc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                mem_en_q, mem_en_d;
  logic [LineSize-1:0] ic_data_q, ic_data_d, dc_data_q, dc_data_d;
  logic                ic_valid_q, ic_valid_d, ic_err_q, ic_err_d;
  logic                dc_valid_q, dc_valid_d, dc_err_q, dc_err_d;
  logic                grant_dc;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    fav_dc_d   = fav_dc_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_en_d   = mem_en_q;
    ic_data_d  = ic_data_q;
    dc_data_d  = dc_data_q;
    ic_valid_d = 1'b0;
    ic_err_d   = 1'b0;
    dc_valid_d = 1'b0;
    dc_err_d   = 1'b0;
    grant_dc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ic_read_en_i || dc_read_en_i) begin
          grant_dc = dc_read_en_i && (!ic_read_en_i || fav_dc_q);
          // The pointer only moves when there was a real contention.
          if (ic_read_en_i && dc_read_en_i) fav_dc_d = ~fav_dc_q;
          owner_dc_d = grant_dc;
          mem_addr_d = (grant_dc ? dc_addr_i : ic_addr_i) & AlignMask;
          mem_en_d   = 1'b1;
          cnt_d      = CntLoad;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (mem_read_valid_i) begin
          if (owner_dc_q) begin
            dc_data_d  = mem_read_data_i;
            dc_valid_d = 1'b1;
          end else begin
            ic_data_d  = mem_read_data_i;
            ic_valid_d = 1'b1;
          end
          mem_en_d = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q == '0) begin
          if (owner_dc_q) dc_err_d = 1'b1;
          else            ic_err_d = 1'b1;
          mem_en_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_dc_q <= 1'b0;
      fav_dc_q   <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
      ic_valid_q <= 1'b0;
      ic_err_q   <= 1'b0;
      dc_valid_q <= 1'b0;
      dc_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      fav_dc_q   <= fav_dc_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q   <= mem_en_d;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
      ic_valid_q <= ic_valid_d;
      ic_err_q   <= ic_err_d;
      dc_valid_q <= dc_valid_d;
      dc_err_q   <= dc_err_d;
    end
  end

  assign ic_read_valid_o = ic_valid_q;
  assign ic_read_data_o  = ic_data_q;
  assign ic_err_o        = ic_err_q;
  assign dc_read_valid_o = dc_valid_q;
  assign dc_read_data_o  = dc_data_q;
  assign dc_err_o        = dc_err_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_read_en_o   = mem_en_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_mem_refill_arbiter;
  localparam int LW = 128;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i = 1'b1;
  logic [31:0]   ic_addr_i = '0, dc_addr_i = '0;
  logic          ic_read_en_i = 1'b0, dc_read_en_i = 1'b0;
  logic          mem_read_valid_i = 1'b0;
  logic [LW-1:0] mem_read_data_i = '0;
  logic          ic_read_valid_o, ic_err_o, dc_read_valid_o, dc_err_o, mem_read_en_o;
  logic [LW-1:0] ic_read_data_o, dc_read_data_o;
  logic [31:0]   mem_addr_o;

  mem_refill_arbiter #(.LineSize(LW), .ByteOffsetBits(4), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_addr_i(ic_addr_i), .ic_read_en_i(ic_read_en_i),
    .ic_read_valid_o(ic_read_valid_o), .ic_read_data_o(ic_read_data_o), .ic_err_o(ic_err_o),
    .dc_addr_i(dc_addr_i), .dc_read_en_i(dc_read_en_i),
    .dc_read_valid_o(dc_read_valid_o), .dc_read_data_o(dc_read_data_o), .dc_err_o(dc_err_o),
    .mem_addr_o(mem_addr_o), .mem_read_en_o(mem_read_en_o),
    .mem_read_valid_i(mem_read_valid_i), .mem_read_data_i(mem_read_data_i)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a refill in flight, its owner and its age in cycles.
  bit            m_busy = 1'b0, m_dc_owns = 1'b0, m_fav_dc = 1'b0;
  int            m_age = 0;
  logic [31:0]   e_addr = '0;
  logic          e_en = 1'b0, e_icv = 1'b0, e_ice = 1'b0, e_dcv = 1'b0, e_dce = 1'b0;
  logic [LW-1:0] e_icd = '0, e_dcd = '0;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_step();
    e_icv = 1'b0; e_ice = 1'b0; e_dcv = 1'b0; e_dce = 1'b0;
    if (rst_i) begin
      m_busy = 1'b0; m_fav_dc = 1'b0; m_age = 0;
      e_en = 1'b0; e_addr = '0; e_icd = '0; e_dcd = '0;
      return;
    end
    if (!m_busy) begin
      if (ic_read_en_i || dc_read_en_i) begin
        m_dc_owns = dc_read_en_i && (!ic_read_en_i || m_fav_dc);
        if (ic_read_en_i && dc_read_en_i) m_fav_dc = !m_fav_dc;
        e_addr = ((m_dc_owns ? dc_addr_i : ic_addr_i) / 16) * 16;
        e_en   = 1'b1;
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else begin
      m_age++;
      if (mem_read_valid_i) begin
        if (m_dc_owns) begin e_dcv = 1'b1; e_dcd = mem_read_data_i; end
        else           begin e_icv = 1'b1; e_icd = mem_read_data_i; end
        m_busy = 1'b0; e_en = 1'b0;
      end else if (m_age == TO) begin
        if (m_dc_owns) e_dce = 1'b1;
        else           e_ice = 1'b1;
        m_busy = 1'b0; e_en = 1'b0;
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare every output.
  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check_eq("mem_addr", mem_addr_o, e_addr);
    check_eq("mem_en", mem_read_en_o, e_en);
    check_eq("ic_valid", ic_read_valid_o, e_icv);
    check_eq("ic_err", ic_err_o, e_ice);
    check_eq("ic_data", ic_read_data_o, e_icd);
    check_eq("dc_valid", dc_read_valid_o, e_dcv);
    check_eq("dc_err", dc_err_o, e_dce);
    check_eq("dc_data", dc_read_data_o, e_dcd);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; ic_read_en_i = 1'b0; dc_read_en_i = 1'b0; mem_read_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  logic [LW-1:0] line_a5;

  initial begin
    line_a5 = {4{32'hA5A5_A5A5}};
    do_reset();
    check_eq("rst_en", mem_read_en_o, 1'b0);
    check_eq("rst_data", ic_read_data_o, '0);

    // T1: IC only, memory answers three cycles after the grant.
    ic_addr_i = 32'h0000_1234; ic_read_en_i = 1'b1;
    tick();
    check_eq("t1_addr", mem_addr_o, 32'h0000_1230);
    check_eq("t1_en", mem_read_en_o, 1'b1);
    tick(); tick();
    mem_read_valid_i = 1'b1; mem_read_data_i = line_a5;
    tick();
    check_eq("t1_valid", ic_read_valid_o, 1'b1);
    check_eq("t1_line", ic_read_data_o, line_a5);
    check_eq("t1_dc", dc_read_data_o, '0);
    mem_read_valid_i = 1'b0; ic_read_en_i = 1'b0;
    tick();
    check_eq("t1_pulse", ic_read_valid_o, 1'b0);

    // T2: simultaneous requests after reset, then again to see the pointer flip.
    do_reset();
    ic_addr_i = 32'h0000_0104; dc_addr_i = 32'h0000_2208;
    ic_read_en_i = 1'b1; dc_read_en_i = 1'b1;
    tick();
    check_eq("t2_ic_first", mem_addr_o, 32'h0000_0100);
    tick();
    mem_read_valid_i = 1'b1; mem_read_data_i = rand_line();
    tick();
    check_eq("t2_ic_valid", ic_read_valid_o, 1'b1);
    mem_read_valid_i = 1'b0; ic_read_en_i = 1'b0;
    tick();
    check_eq("t2_dc_next", mem_addr_o, 32'h0000_2200);
    check_eq("t2_dc_en", mem_read_en_o, 1'b1);
    mem_read_valid_i = 1'b1; mem_read_data_i = rand_line();
    tick();
    check_eq("t2_dc_valid", dc_read_valid_o, 1'b1);
    mem_read_valid_i = 1'b0; dc_read_en_i = 1'b0;
    tick();
    ic_read_en_i = 1'b1; dc_read_en_i = 1'b1;
    tick();
    check_eq("t2_dc_first", mem_addr_o, 32'h0000_2200);
    mem_read_valid_i = 1'b1; mem_read_data_i = rand_line();
    tick();
    check_eq("t2_dc_valid2", dc_read_valid_o, 1'b1);
    mem_read_valid_i = 1'b0; dc_read_en_i = 1'b0;
    tick();
    check_eq("t2_ic_after", mem_addr_o, 32'h0000_0100);
    mem_read_valid_i = 1'b1; mem_read_data_i = rand_line();
    tick();
    mem_read_valid_i = 1'b0; ic_read_en_i = 1'b0;
    tick();

    // T3: DC request with no memory answer times out exactly TO cycles later.
    dc_addr_i = 32'h0000_0040; dc_read_en_i = 1'b1;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check_eq("t3_early_err", dc_err_o, 1'b0);
    end
    tick();
    check_eq("t3_err", dc_err_o, 1'b1);
    check_eq("t3_en_drop", mem_read_en_o, 1'b0);
    check_eq("t3_no_valid", dc_read_valid_o, 1'b0);
    dc_read_en_i = 1'b0;
    tick();

    // T4: memory answers on the timeout edge; the answer wins.
    dc_read_en_i = 1'b1;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    mem_read_valid_i = 1'b1; mem_read_data_i = rand_line();
    tick();
    check_eq("t4_valid", dc_read_valid_o, 1'b1);
    check_eq("t4_no_err", dc_err_o, 1'b0);
    mem_read_valid_i = 1'b0; dc_read_en_i = 1'b0;
    tick();

    // T5: reset two cycles into BUSY aborts silently.
    ic_addr_i = 32'h0000_8888; ic_read_en_i = 1'b1;
    tick(); tick(); tick();
    rst_i = 1'b1;
    tick();
    check_eq("t5_en", mem_read_en_o, 1'b0);
    check_eq("t5_addr", mem_addr_o, 32'h0);
    check_eq("t5_dc_data", dc_read_data_o, '0);
    rst_i = 1'b0; ic_read_en_i = 1'b0;
    mem_read_valid_i = 1'b1; mem_read_data_i = rand_line();
    tick();
    check_eq("t5_late_valid", ic_read_valid_o, 1'b0);

    // T6: memory strobes in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      mem_read_data_i = rand_line();
      tick();
      check_eq("t6_idle_data", ic_read_data_o, '0);
    end
    mem_read_valid_i = 1'b0;

    // Random traffic: requesters hold until their pulse, memory answers at random.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ic_read_en_i && (e_icv || e_ice)) ic_read_en_i = 1'b0;
      else if (!ic_read_en_i && $urandom_range(3) == 0) begin
        ic_read_en_i = 1'b1; ic_addr_i = $urandom;
      end
      if (dc_read_en_i && (e_dcv || e_dce)) dc_read_en_i = 1'b0;
      else if (!dc_read_en_i && $urandom_range(3) == 0) begin
        dc_read_en_i = 1'b1; dc_addr_i = $urandom;
      end
      mem_read_valid_i = e_en ? ($urandom_range(9) == 0) : ($urandom_range(7) == 0);
      mem_read_data_i  = rand_line();
      rst_i            = ($urandom_range(299) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
